// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared constants and helpers for the multiplexed seven-segment
//            driver. Holds the hex-to-segment table (common-anode, active-low,
//            bit0..6 = a..g, bit7 = dp) and the all-off pattern.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Indexed by nibble value; entry 0 sits in the low byte.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_if.sv
`default_nettype none
// ============================================================================
// Module   : sseg_if
// Purpose  : Bundle between board display logic (master) and the segment
//            driver (slave).
// Signals  : display_data  4*DIGITS  hex nibbles, nibble i -> digit i
//            dp            DIGITS    decimal points (1 = lit)
//            digit_en      DIGITS    per-digit enable (0 = blank)
//            lz_blank      1         leading-zero suppression enable
//            brightness    BRIGHT_W  PWM duty, all-ones = 100%
//            sseg          8         active-low segments, bit7 = dp
//            an            DIGITS    active-low anodes
//            frame_start   1         pulse on first cycle of digit 0
// Revision : 1.0 - initial release
// ============================================================================
interface sseg_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] display_data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   digit_en;
    logic                lz_blank;
    logic [BRIGHT_W-1:0] brightness;
    logic [7:0]          sseg;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output display_data, dp, digit_en, lz_blank, brightness,
        input  sseg, an, frame_start
    );

    modport slave (
        input  display_data, dp, digit_en, lz_blank, brightness,
        output sseg, an, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/sseg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : sseg_hex_decode
// Purpose  : Combinational nibble + decimal point -> active-low segment
//            pattern for a common-anode digit.
// Ports    : nibble_i  4  hex value
//            dp_i      1  decimal point request (1 = lit)
//            seg_o     8  active-low pattern, bit7 = dp
// Revision : 1.0 - initial release
// ============================================================================
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);
    logic [7:0] base_w;

    assign base_w = hex2seg(nibble_i);
    assign seg_o  = {base_w[7] & ~dp_i, base_w[6:0]};
endmodule
`default_nettype wire

// File: rtl/sseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : sseg_mux_n
// Purpose  : Time-multiplexed driver for DIGITS common-anode digits with
//            per-digit dp/enable, leading-zero blanking, PWM brightness and
//            frame-synchronous latching of the display inputs.
// Ports    : clk    1  system clock
//            clear  1  synchronous active-high reset
//            bus    sseg_if.slave (display inputs in, sseg/an/frame_start out)
// Revision : 1.0 - initial release
// ============================================================================
module sseg_mux_n
    import sseg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int REFRESH_W = 17,
    parameter int BRIGHT_W  = 4
) (
    input  logic   clk,
    input  logic   clear,
    sseg_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [REFRESH_W-1:0] cnt_q;
    logic [IDX_W-1:0]     idx_q, idx_d;

    // Shadow copies: the frame being shown never sees mid-frame input edits.
    logic [4*DIGITS-1:0]  data_sh_q;
    logic [DIGITS-1:0]    dp_sh_q;
    logic [DIGITS-1:0]    en_sh_q;
    logic                 lz_sh_q;

    logic [7:0]           sseg_q, sseg_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic                 fs_q, fs_d;

    logic                 cnt_wrap;
    logic                 last_digit;
    logic                 frame_wrap;
    logic [3:0]           cur_nib;
    logic [7:0]           dec_seg;
    logic [DIGITS-1:0]    lz_zero;
    logic                 zero_run;
    logic                 pwm_on;
    logic                 blank;

    assign cnt_wrap   = &cnt_q;
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
    assign frame_wrap = cnt_wrap & last_digit;

    always_comb begin
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
    end

    assign cur_nib = data_sh_q[{idx_q, 2'b00} +: 4];

    // lz_zero[i] = nibble i and every nibble above it are zero.
    always_comb begin
        lz_zero  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (data_sh_q[4*i +: 4] == 4'h0);
            lz_zero[i] = zero_run;
        end
    end

    // Top BRIGHT_W bits of the dwell counter act as the PWM phase.
    assign pwm_on = (cnt_q[REFRESH_W-1 -: BRIGHT_W] <= bus.brightness);

    assign blank = ~en_sh_q[idx_q]
                 | (lz_sh_q & lz_zero[idx_q] & (idx_q != '0))
                 | ~pwm_on;

    sseg_hex_decode u_decode (
        .nibble_i (cur_nib),
        .dp_i     (dp_sh_q[idx_q]),
        .seg_o    (dec_seg)
    );

    always_comb begin
        sseg_d = SEG_BLANK;
        an_d   = '1;
        fs_d   = (cnt_q == '0) && (idx_q == '0);
        if (!blank) begin
            sseg_d = dec_seg;
            an_d   = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sseg_q    <= SEG_BLANK;
            an_q      <= '1;
            fs_q      <= 1'b0;
            data_sh_q <= bus.display_data;
            dp_sh_q   <= bus.dp;
            en_sh_q   <= bus.digit_en;
            lz_sh_q   <= bus.lz_blank;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            idx_q  <= idx_d;
            sseg_q <= sseg_d;
            an_q   <= an_d;
            fs_q   <= fs_d;
            if (frame_wrap) begin
                data_sh_q <= bus.display_data;
                dp_sh_q   <= bus.dp;
                en_sh_q   <= bus.digit_en;
                lz_sh_q   <= bus.lz_blank;
            end
        end
    end

    assign bus.sseg        = sseg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;
endmodule
`default_nettype wire

// File: tb/tb_sseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_mux_n
// Purpose  : Self-checking bench for sseg_mux_n with DIGITS=4, REFRESH_W=3,
//            BRIGHT_W=2 (8-cycle slots, 32-cycle frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_mux_n;
    localparam int DIGITS    = 4;
    localparam int REFRESH_W = 3;
    localparam int BRIGHT_W  = 2;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    sseg_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

    sseg_mux_n #(
        .DIGITS    (DIGITS),
        .REFRESH_W (REFRESH_W),
        .BRIGHT_W  (BRIGHT_W)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0]       en;
        logic             lz;
        logic [1:0]       br;
        logic [3:0][7:0]  segs;   // expected pattern per digit, FF = blank
    } vec_t;

    vec_t vecs [7];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Checks output cycles j0..j1 of a frame, starting at the current negedge.
    task automatic check_part(input logic [3:0][7:0] segs, input logic [1:0] br,
                              input int j0, input int j1, input string tag);
        for (int j = j0; j <= j1; j++) begin
            int d;
            int c;
            logic       lit;
            logic [7:0] es;
            logic [3:0] ea;
            d   = j / 8;
            c   = j % 8;
            lit = (segs[d] != 8'hFF) && ((c >> 1) <= int'(br));
            es  = lit ? segs[d] : 8'hFF;
            ea  = lit ? ~(4'b0001 << d) : 4'hF;
            chk($sformatf("%s j%0d an", tag, j), {4'h0, bus.an}, {4'h0, ea});
            chk($sformatf("%s j%0d sseg", tag, j), bus.sseg, es);
            chk($sformatf("%s j%0d frame_start", tag, j), {7'h0, bus.frame_start},
                {7'h0, (j == 0)});
            @(negedge clk);
        end
    endtask

    task automatic seek_frame(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.frame_start === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s seek: got no frame_start, expected one within 100 cycles", tag);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.display_data = v.data;
        bus.dp           = v.dp;
        bus.digit_en     = v.en;
        bus.lz_blank     = v.lz;
        bus.brightness   = v.br;
    endtask

    initial begin
        logic [3:0][7:0] s8320;
        logic [3:0][7:0] sabcd;
        logic [3:0][7:0] s1234;

        s8320 = {8'h80, 8'hB0, 8'hA4, 8'hC0};
        sabcd = {8'h88, 8'h83, 8'hC6, 8'hA1};
        s1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};

        vecs[0] = '{data:16'h0050, dp:4'h0, en:4'hF, lz:1'b1, br:2'd3, segs:{8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vecs[1] = '{data:16'h0000, dp:4'h0, en:4'hF, lz:1'b1, br:2'd3, segs:{8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[2] = '{data:16'h8888, dp:4'b0100, en:4'b1011, lz:1'b0, br:2'd3, segs:{8'h80, 8'hFF, 8'h80, 8'h80}};
        vecs[3] = '{data:16'h8320, dp:4'h0, en:4'hF, lz:1'b0, br:2'd0, segs:{8'h80, 8'hB0, 8'hA4, 8'hC0}};
        vecs[4] = '{data:16'h0102, dp:4'b1011, en:4'hF, lz:1'b1, br:2'd3, segs:{8'hFF, 8'hF9, 8'h40, 8'h24}};
        vecs[5] = '{data:16'h7E96, dp:4'h0, en:4'hF, lz:1'b1, br:2'd2, segs:{8'hF8, 8'h86, 8'h90, 8'h82}};
        vecs[6] = '{data:16'h4F15, dp:4'h0, en:4'hF, lz:1'b0, br:2'd1, segs:{8'h99, 8'h8E, 8'hF9, 8'h92}};

        // Reset with the basic pattern, clear held for two edges.
        clear = 1'b1;
        apply('{data:16'h8320, dp:4'h0, en:4'hF, lz:1'b0, br:2'd3, segs:s8320});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset an", {4'h0, bus.an}, 8'h0F);
        chk("reset sseg", bus.sseg, 8'hFF);
        chk("reset frame_start", {7'h0, bus.frame_start}, 8'h00);
        clear = 1'b0;
        @(negedge clk);

        // First frame after clear begins right away.
        check_part(s8320, 2'd3, 0, 31, "t1");

        // Mid-frame data change (during digit 1) must wait for the next frame.
        check_part(s8320, 2'd3, 0, 9, "t2a");
        bus.display_data = 16'hABCD;
        check_part(s8320, 2'd3, 10, 31, "t2b");
        check_part(sabcd, 2'd3, 0, 31, "t2c");

        for (int v = 0; v < 7; v++) begin
            apply(vecs[v]);
            seek_frame($sformatf("v%0d", v));
            @(negedge clk);
            seek_frame($sformatf("v%0d", v));
            check_part(vecs[v].segs, vecs[v].br, 0, 31, $sformatf("v%0d", v));
        end

        // Clear pulsed while digit 2 is on screen, together with new data.
        seek_frame("t6");
        repeat (18) @(negedge clk);
        clear = 1'b1;
        apply('{data:16'h1234, dp:4'h0, en:4'hF, lz:1'b0, br:2'd3, segs:s1234});
        @(negedge clk);
        chk("t6 clear an", {4'h0, bus.an}, 8'h0F);
        chk("t6 clear sseg", bus.sseg, 8'hFF);
        chk("t6 clear frame_start", {7'h0, bus.frame_start}, 8'h00);
        clear = 1'b0;
        @(negedge clk);
        check_part(s1234, 2'd3, 0, 31, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
